window_gen: RTL and testbench

WINDOW_GEN -- requirements
Module: window_gen

---
 rtl/window_gen.sv | 204 ++++++++++++++++++++
 tb/tb_window_gen.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_gen.sv
// Sliding SxS window generator over a raster-order image stream with S-1 line buffers.
// Latency: a window is registered and presented one cycle after its completing pixel is accepted.
// Backpressure: pix_ready drops while an untaken window is held or while the frame's final window is pending.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-low reset
//   pix_in     - pixel data, raster order, row 0 col 0 first
//   pix_valid  - pix_in holds a valid pixel
//   pix_ready  - pixel accepted this cycle when high together with pix_valid
//   win        - packed SxS window, element (r,c) at win[DATA_WIDTH*(r*S+c) +: DATA_WIDTH]
//   win_valid  - win holds a valid window
//   win_ready  - downstream takes win this cycle when high together with win_valid
//   frame_done - one-cycle pulse after the last window of a frame is taken
module window_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int S          = 5,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        pix_in,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  output logic [S*S*DATA_WIDTH-1:0]    win,
  output logic                         win_valid,
  input  logic                         win_ready,
  output logic                         frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_WIN       = CW'(S - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FILL_LAST = RW'(S - 2);
  localparam logic [RW-1:0] ROW_WIN       = RW'(S - 1);

  typedef enum logic [1:0] {
    FILL,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic accept;
  logic xfer;
  logic produce;
  logic col_wrap;

  // lb[k][x] holds column x of image row (row-S+1+k) relative to the row
  // currently being received; lb[0] is the oldest row.
  logic [DATA_WIDTH-1:0] lb [S-1][IMG_W];

  // Sliding window registers, sr[r][c]; column S-1 is the most recent column.
  logic [DATA_WIDTH-1:0] sr     [S][S];
  logic [DATA_WIDTH-1:0] sr_nxt [S][S];

  // The full S-tall image column at the current col: S-1 buffered rows plus the
  // incoming pixel at the bottom.
  logic [DATA_WIDTH-1:0] col_vec [S];

  logic [S*S*DATA_WIDTH-1:0] win_nxt;

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  assign pix_ready = (!win_valid || win_ready) && (state != DONE);
  assign accept    = pix_valid && pix_ready;
  assign xfer      = win_valid && win_ready;
  assign col_wrap  = (col == COL_LAST);

  // Only pixels in the lower-right region complete a full SxS neighbourhood.
  assign produce   = accept && (row >= ROW_WIN) && (col >= COL_WIN);

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (accept && col_wrap && (row == ROW_FILL_LAST)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (accept && col_wrap && (row == ROW_LAST)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (xfer) begin
          state_nxt = FILL;
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Position counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if ((state == DONE) && xfer) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Window datapath
  // --------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < S - 1; r++) begin
      col_vec[r] = lb[r][col];
    end
    col_vec[S-1] = pix_in;
  end

  // Shift the window one column left and append the new image column on the right.
  always_comb begin
    for (int r = 0; r < S; r++) begin
      for (int c = 0; c < S - 1; c++) begin
        sr_nxt[r][c] = sr[r][c+1];
      end
      sr_nxt[r][S-1] = col_vec[r];
    end
  end

  always_comb begin
    win_nxt = '0;
    for (int r = 0; r < S; r++) begin
      for (int c = 0; c < S; c++) begin
        win_nxt[DATA_WIDTH*(r*S+c) +: DATA_WIDTH] = sr_nxt[r][c];
      end
    end
  end

  // Line buffers and window shift register carry no reset: after a reset the
  // FILL rows overwrite every buffered column before any window is produced,
  // and the first S-1 columns of each row flush the window registers.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < S - 1; k++) begin
        lb[k][col] <= col_vec[k+1];
      end
      for (int r = 0; r < S; r++) begin
        for (int c = 0; c < S; c++) begin
          sr[r][c] <= sr_nxt[r][c];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  // A new window can only load when the previous one is gone or leaving this
  // cycle, because produce implies pix_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == DONE) && xfer;
      if (produce) begin
        win       <= win_nxt;
        win_valid <= 1'b1;
      end else if (xfer) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_gen.sv
// Self-checking bench for window_gen with a 3x3 window over a 4x4 image.
// Latency: not applicable.
// Backpressure: the bench drives both win_ready stalls and pix_valid gaps.
module tb_window_gen;

  localparam int DW   = 32;
  localparam int S    = 3;
  localparam int IW   = 4;
  localparam int IH   = 4;
  localparam int WW   = S * S * DW;
  localparam int NWIN = (IW - S + 1) * (IH - S + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [WW-1:0] win;
  logic          win_valid;
  logic          win_ready;
  logic          frame_done;

  window_gen #(
    .DATA_WIDTH (DW),
    .S          (S),
    .IMG_W      (IW),
    .IMG_H      (IH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win        (win),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Window whose top-left pixel has value base, for images where pixel value == raster index.
  function automatic logic [WW-1:0] win_at(input int base);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++)
        w[DW*(r*S+c) +: DW] = DW'(base + r*IW + c);
    return w;
  endfunction

  // --------------------------------------------------------------------------
  // Protocol monitor and capture
  // --------------------------------------------------------------------------
  logic [DW-1:0] src_q [$];
  logic [WW-1:0] got_q [$];
  int            pos;
  int            nxfer;
  int            fd_cnt = 0;
  bit            exp_wv;
  bit            exp_fd;
  bit            prev_hold;
  logic [WW-1:0] prev_win;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (exp_wv) chk("latency_win_valid", int'(win_valid), 1);
      chk("frame_done_timing", int'(frame_done), int'(exp_fd));
      if (prev_hold) begin
        chk("hold_win_valid", int'(win_valid), 1);
        chk_w("hold_win", win, prev_win);
      end
      if (win_valid && !win_ready) chk("stall_pix_ready", int'(pix_ready), 0);
      if (frame_done) fd_cnt++;

      exp_wv = 1'b0;
      exp_fd = 1'b0;
      if (pix_valid && pix_ready) begin
        if ((pos / IW >= S - 1) && (pos % IW >= S - 1)) exp_wv = 1'b1;
        pos = (pos + 1) % (IW * IH);
      end
      if (win_valid && win_ready) begin
        got_q.push_back(win);
        nxfer++;
        if (nxfer == NWIN) begin
          exp_fd = 1'b1;
          nxfer  = 0;
        end
      end
      prev_hold = win_valid && !win_ready;
      prev_win  = win;
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    pix_in    = '0;
    win_ready = 1'b1;
    rst       = 1'b0;
    pos       = 0;
    nxfer     = 0;
    exp_wv    = 1'b0;
    exp_fd    = 1'b0;
    prev_hold = 1'b0;
    got_q.delete();
    @(negedge clk);
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_pix_ready", int'(pix_ready), 1);
    chk_w("rst_win", win, '0);
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic fill_seq(input int base);
    for (int k = 0; k < IW * IH; k++) src_q.push_back(DW'(base + k));
  endtask

  // Streams src_q[start..] and runs until nframes more frame_done pulses are seen.
  task automatic run_stream(input int start, input bit pv_rand, input bit wr_rand, input int nframes);
    int idx;
    int budget;
    int target;
    idx    = start;
    budget = 0;
    target = fd_cnt + nframes;
    while ((idx < src_q.size() || fd_cnt < target) && budget < 3000) begin
      if (idx < src_q.size()) begin
        pix_valid = pv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_in    = src_q[idx];
      end else begin
        pix_valid = 1'b0;
        pix_in    = '0;
      end
      win_ready = wr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (pix_valid && pix_ready) idx++;
      tick();
      budget++;
    end
    pix_valid = 1'b0;
    win_ready = 1'b1;
    chk("stream_completed", int'(fd_cnt >= target), 1);
  endtask

  // Reference: every SxS neighbourhood of each source frame, row-major.
  task automatic check_windows(input int nframes);
    logic [WW-1:0] e;
    int k;
    k = 0;
    chk("window_count", got_q.size(), nframes * NWIN);
    for (int f = 0; f < nframes; f++)
      for (int rr = S - 1; rr < IH; rr++)
        for (int cc = S - 1; cc < IW; cc++) begin
          e = '0;
          for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++)
              e[DW*(r*S+c) +: DW] = src_q[f*IW*IH + (rr-S+1+r)*IW + (cc-S+1+c)];
          if (k < got_q.size()) chk_w("window_data", got_q[k], e);
          k++;
        end
  endtask

  typedef struct {
    bit pv;
    int px;
    bit wr;
    bit pr;
    bit wv;
    bit fd;
    int base;
  } vec_t;

  function automatic vec_t mkv(input bit pv, input int px, input bit wr,
                               input bit pr, input bit wv, input bit fd, input int base);
    vec_t v;
    v.pv = pv; v.px = px; v.wr = wr;
    v.pr = pr; v.wv = wv; v.fd = fd; v.base = base;
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  vec_t tv [19];

  initial begin
    int fd0;

    // Cycle-by-cycle table for one frame: pixel k driven on cycle k.
    for (int k = 0; k < 16; k++) tv[k] = mkv(1, k, 1, 1, 0, 0, 0);
    tv[11] = mkv(1, 11, 1, 1, 1, 0, 0);
    tv[12] = mkv(1, 12, 1, 1, 1, 0, 1);
    tv[15] = mkv(1, 15, 1, 1, 1, 0, 4);
    tv[16] = mkv(0, 0,  1, 0, 1, 0, 5);
    tv[17] = mkv(0, 0,  1, 1, 0, 1, 0);
    tv[18] = mkv(0, 0,  1, 1, 0, 0, 0);

    do_reset();
    src_q.delete();
    fill_seq(0);
    for (int i = 0; i < 19; i++) begin
      pix_valid = tv[i].pv;
      pix_in    = DW'(tv[i].px);
      win_ready = tv[i].wr;
      @(negedge clk);
      chk("tv_pix_ready", int'(pix_ready), int'(tv[i].pr));
      chk("tv_win_valid", int'(win_valid), int'(tv[i].wv));
      chk("tv_frame_done", int'(frame_done), int'(tv[i].fd));
      if (tv[i].wv) chk_w("tv_win", win, win_at(tv[i].base));
      tick();
    end
    check_windows(1);

    // Downstream stall on the first window.
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      pix_valid = 1'b1; pix_in = DW'(k); win_ready = 1'b1;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1'b1; pix_in = DW'(11); win_ready = 1'b0;
      @(negedge clk);
      chk("stall_ready_low", int'(pix_ready), 0);
      chk("stall_valid", int'(win_valid), 1);
      chk_w("stall_win", win, win_at(0));
      tick();
    end
    win_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", int'(pix_ready), 1);
    tick();
    pix_valid = 1'b0;
    @(negedge clk);
    chk("second_win_valid", int'(win_valid), 1);
    chk_w("second_win", win, win_at(1));
    tick();
    fd0 = fd_cnt;
    run_stream(12, 0, 0, 1);
    check_windows(1);
    chk("stall_frame_done_cnt", fd_cnt - fd0, 1);

    // Random pixel gaps, downstream always ready.
    do_reset();
    run_stream(0, 1, 0, 1);
    check_windows(1);

    // Reset in the middle of a frame, then a full resend.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      pix_valid = 1'b1; pix_in = DW'(k); win_ready = 1'b1;
      tick();
    end
    do_reset();
    chk("post_reset_no_window", int'(win_valid), 0);
    run_stream(0, 0, 0, 1);
    check_windows(1);

    // Two back-to-back frames.
    do_reset();
    src_q.delete();
    fill_seq(0);
    fill_seq(100);
    fd0 = fd_cnt;
    run_stream(0, 0, 0, 2);
    check_windows(2);
    if (got_q.size() > 4) chk_w("frame2_first_win", got_q[4], win_at(100));
    chk("two_frame_done_cnt", fd_cnt - fd0, 2);

    // Random data, random pixel gaps and random downstream stalls over three frames.
    do_reset();
    src_q.delete();
    for (int k = 0; k < 3 * IW * IH; k++) src_q.push_back(DW'($urandom));
    run_stream(0, 1, 1, 3);
    check_windows(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

endmodule
